snake_body_engine: RTL and testbench

//  Parametrised snake-body engine: replaces the fixed 160-entry shift-array datapath with a ring buffer of segment coordinates.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_pix_if.sv | 14 +
 rtl/snake_ring_buffer.sv | 35 +++
 rtl/snake_body_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: direction and FSM state encodings,
// pixel colour constants and the direction-reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    UP    = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    INIT,
    WAIT,
    CHECK,
    ERASE,
    DRAW,
    DEAD
  } state_t;

  localparam logic [2:0] COL_DRAW  = 3'b111;
  localparam logic [2:0] COL_ERASE = 3'b000;

  // The encoding places each direction's reverse at its bitwise complement.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/snake_pix_if.sv
// Valid/ready pixel stream between the snake engine and the plot sink.
interface snake_pix_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) ();
  logic           p_valid;
  logic           p_ready;
  logic [X_W-1:0] p_x;
  logic [Y_W-1:0] p_y;
  logic [2:0]     p_col;

  modport master (output p_valid, p_x, p_y, p_col, input p_ready);
  modport slave  (input p_valid, p_x, p_y, p_col, output p_ready);
endinterface

// File: rtl/snake_ring_buffer.sv
// Segment coordinate store: one write port, one registered read port (1-cycle
// latency) and a loadable head pointer.
module snake_ring_buffer #(
  parameter  int X_W      = 8,
  parameter  int Y_W      = 7,
  parameter  int MAX_LEN  = 160,
  parameter  int INIT_LEN = 4,
  localparam int PTR_W    = $clog2(MAX_LEN),
  localparam int SEG_W    = X_W + Y_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [SEG_W-1:0] wdata,
  input  logic             advance,
  input  logic [PTR_W-1:0] raddr,
  output logic [SEG_W-1:0] rdata,
  output logic [PTR_W-1:0] head_ptr
);

  logic [SEG_W-1:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  // Advancing always lands on the slot just written, so the write address is reused.
  always_ff @(posedge clk) begin
    if (reset) head_ptr <= PTR_W'(INIT_LEN - 1);
    else if (advance) head_ptr <= waddr;
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: ring-buffered body, direction arbitration, growth, self-collision
// and a valid/ready pixel stream. Define WRAP_EN for wrap-around playfield edges.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter  int X_W       = 8,
  parameter  int Y_W       = 7,
  parameter  int GRID_W    = 160,
  parameter  int GRID_H    = 120,
  parameter  int MAX_LEN   = 160,
  parameter  int INIT_LEN  = 4,
  parameter  int GROW_STEP = 4,
  parameter  int START_X   = 80,
  parameter  int START_Y   = 60,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             dir_valid,
  input  logic [1:0]       dir_req,
  input  logic [X_W-1:0]   food_x,
  input  logic [Y_W-1:0]   food_y,
  snake_pix_if.master      pix,
  output logic             eat,
  output logic [LEN_W-1:0] length,
  output logic [7:0]       score,
  output logic             game_over
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int SEG_W = X_W + Y_W;

  state_t           state;
  dir_t             dir, req, new_dir;
  logic             req_vld, tick_pend, pv, erase_sel;
  logic [LEN_W-1:0] grow_pend, idx, n_cmp, grow_eff;
  logic [X_W-1:0]   head_x, nx, px, cand_x;
  logic [Y_W-1:0]   head_y, ny, py, cand_y;
  logic [2:0]       pcol;
  logic [PTR_W-1:0] head_ptr, raddr, waddr;
  logic [SEG_W-1:0] rdata, wdata;
  logic             we, advance, xfer, hit, food_hit;

  function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] p,
                                               input logic [LEN_W-1:0] off);
    int t;
    t = int'(p) - int'(off);
    if (t < 0) t += MAX_LEN;
    return PTR_W'(t);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Pending growth after an optional meal, never letting length+grow exceed MAX_LEN.
  function automatic logic [LEN_W-1:0] grow_next(input logic [LEN_W-1:0] g,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic ate);
    int want, room;
    want = int'(g) + (ate ? GROW_STEP : 0);
    room = MAX_LEN - int'(len);
    return LEN_W'((want > room) ? room : want);
  endfunction

`ifndef WRAP_EN
  function automatic logic leaves_grid(input dir_t d, input logic [X_W-1:0] x,
                                       input logic [Y_W-1:0] y);
    case (d)
      RIGHT:   return x == X_W'(GRID_W - 1);
      LEFT:    return x == '0;
      DOWN:    return y == Y_W'(GRID_H - 1);
      default: return y == '0;
    endcase
  endfunction
`endif

  snake_ring_buffer #(
    .X_W(X_W), .Y_W(Y_W), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)
  ) u_ring (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .advance(advance), .raddr(raddr), .rdata(rdata), .head_ptr(head_ptr)
  );

  assign xfer     = pv & pix.p_ready;
  assign n_cmp    = (grow_pend == '0) ? length - LEN_W'(1) : length;
  assign raddr    = ptr_sub(head_ptr, idx);
  assign hit      = (rdata == {nx, ny});
  assign food_hit = (nx == food_x) && (ny == food_y);
  assign grow_eff = grow_next(grow_pend, length, food_hit);
  assign new_dir  = req_vld ? req : dir;

  assign pix.p_valid = pv;
  assign pix.p_x     = erase_sel ? rdata[SEG_W-1 -: X_W] : px;
  assign pix.p_y     = erase_sel ? rdata[Y_W-1:0] : py;
  assign pix.p_col   = pcol;

  always_comb begin
    cand_x = head_x;
    cand_y = head_y;
    case (new_dir)
      RIGHT:   cand_x = (head_x == X_W'(GRID_W - 1)) ? '0 : head_x + X_W'(1);
      LEFT:    cand_x = (head_x == '0) ? X_W'(GRID_W - 1) : head_x - X_W'(1);
      DOWN:    cand_y = (head_y == Y_W'(GRID_H - 1)) ? '0 : head_y + Y_W'(1);
      default: cand_y = (head_y == '0) ? Y_W'(GRID_H - 1) : head_y - Y_W'(1);
    endcase
  end

  always_comb begin
    we      = 1'b0;
    advance = 1'b0;
    waddr   = ptr_inc(head_ptr);
    wdata   = {nx, ny};
    if (xfer && state == INIT) begin
      we    = 1'b1;
      waddr = PTR_W'(INIT_LEN - 1 - int'(idx));
      wdata = {px, py};
    end else if (xfer && state == DRAW) begin
      we      = 1'b1;
      advance = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      dir       <= RIGHT;
      req       <= RIGHT;
      req_vld   <= 1'b0;
      tick_pend <= 1'b0;
      length    <= LEN_W'(INIT_LEN);
      grow_pend <= '0;
      score     <= '0;
      eat       <= 1'b0;
      game_over <= 1'b0;
      pv        <= 1'b0;
      erase_sel <= 1'b0;
      idx       <= '0;
      head_x    <= X_W'(START_X);
      head_y    <= Y_W'(START_Y);
    end else begin
      eat <= 1'b0;
      if (tick && state inside {INIT, CHECK, ERASE, DRAW}) tick_pend <= 1'b1;
      case (state)
        INIT: begin
          if (xfer && idx == LEN_W'(INIT_LEN - 1)) begin
            pv    <= 1'b0;
            idx   <= '0;
            state <= WAIT;
          end else if (!pv || xfer) begin
            pv   <= 1'b1;
            pcol <= COL_DRAW;
            px   <= X_W'(START_X - int'(idx) - (xfer ? 1 : 0));
            py   <= Y_W'(START_Y);
            idx  <= xfer ? idx + LEN_W'(1) : idx;
          end
        end
        WAIT: begin
          if (tick || tick_pend) begin
            tick_pend <= 1'b0;
            dir       <= new_dir;
            req_vld   <= 1'b0;
`ifndef WRAP_EN
            if (leaves_grid(new_dir, head_x, head_y)) begin
              state     <= DEAD;
              game_over <= 1'b1;
            end else
`endif
            begin
              nx    <= cand_x;
              ny    <= cand_y;
              idx   <= '0;
              state <= CHECK;
            end
          end
        end
        // rdata lags raddr by one cycle, so segment k is compared while idx == k+1.
        CHECK: begin
          if (idx != '0 && hit) begin
            state     <= DEAD;
            game_over <= 1'b1;
          end else if (idx == n_cmp) begin
            eat       <= food_hit;
            if (food_hit) score <= sat_inc(score);
            grow_pend <= grow_eff;
            pv        <= 1'b1;
            if (grow_eff == '0) begin
              state     <= ERASE;
              erase_sel <= 1'b1;
              pcol      <= COL_ERASE;
            end else begin
              state     <= DRAW;
              erase_sel <= 1'b0;
              pcol      <= COL_DRAW;
              px        <= nx;
              py        <= ny;
            end
          end else begin
            idx <= idx + LEN_W'(1);
          end
        end
        ERASE: begin
          if (xfer) begin
            state     <= DRAW;
            erase_sel <= 1'b0;
            pcol      <= COL_DRAW;
            px        <= nx;
            py        <= ny;
          end
        end
        DRAW: begin
          if (xfer) begin
            pv     <= 1'b0;
            head_x <= nx;
            head_y <= ny;
            if (grow_pend != '0) begin
              length    <= length + LEN_W'(1);
              grow_pend <= grow_pend - LEN_W'(1);
            end
            state <= WAIT;
          end
        end
        default: pv <= 1'b0;
      endcase
      if (dir_valid && dir_t'(dir_req) != opposite(dir)) begin
        req     <= dir_t'(dir_req);
        req_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: init draw, moves, steering, eating and growth,
// back-pressure, self-collision, reset recovery, pending ticks and the right edge.
module tb_snake_body_engine;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic [7:0] food_x = 8'd0;
  logic [6:0] food_y = 7'd0;
  logic       eat;
  logic [7:0] length;
  logic [7:0] score;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  logic [17:0] pix_log [0:4095];
  int pix_cnt = 0;
  int eat_cnt = 0;
  int rd_idx = 0;

  snake_pix_if #(.X_W(8), .Y_W(7)) pif ();

  snake_body_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .dir_valid(dir_valid), .dir_req(dir_req),
    .food_x(food_x), .food_y(food_y), .pix(pif), .eat(eat), .length(length),
    .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pif.p_valid === 1'b1 && pif.p_ready === 1'b1 && pix_cnt < 4096) begin
      pix_log[pix_cnt] = {pif.p_x, pif.p_y, pif.p_col};
      pix_cnt++;
    end
    if (eat === 1'b1) eat_cnt++;
  end

  function automatic logic [31:0] pk(input int x, input int y, input int c);
    return {14'd0, 8'(x), 7'(y), 3'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic set_dir(input dir_t d);
    dir_valid = 1'b1;
    dir_req   = d;
    step();
    dir_valid = 1'b0;
  endtask

  task automatic exp_pix(input string tag, input int x, input int y, input int c);
    int n;
    logic [31:0] got;
    n = 0;
    while (pix_cnt - rd_idx < 1 && n < 200) begin
      step();
      n++;
    end
    got = 32'hFFFF_FFFF;
    if (pix_cnt - rd_idx >= 1) begin
      got = {14'd0, pix_log[rd_idx]};
      rd_idx++;
    end
    chk(tag, got, pk(x, y, c));
  endtask

  task automatic move(input int ex, input int ey, input int dx, input int dy);
    pulse_tick();
    exp_pix("erase", ex, ey, 0);
    exp_pix("draw", dx, dy, 7);
  endtask

  task automatic wait_pvalid(input string tag);
    int n;
    n = 0;
    while (pif.p_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(tag, pif.p_valid, 1);
  endtask

  task automatic wait_dead(input string tag);
    int n;
    n = 0;
    while (game_over !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(tag, game_over, 1);
  endtask

  task automatic hold_check(input string tag, input int x, input int y, input int c);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_valid"}, pif.p_valid, 1);
      chk(tag, {14'd0, pif.p_x, pif.p_y, pif.p_col}, pk(x, y, c));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    pif.p_ready = 1'b1;
    step(3);
    chk("rst_p_valid", pif.p_valid, 0);
    chk("rst_length", length, 4);
    chk("rst_score", score, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_eat", eat, 0);
    reset  = 1'b0;
    rd_idx = pix_cnt;
    for (int i = 0; i < 4; i++) exp_pix("init", 80 - i, 60, 7);
    chk("init_length", length, 4);
    chk("init_game_over", game_over, 0);

    // Straight moves; first one also checks tick-to-pixel latency (3 compares).
    e0 = eat_cnt;
    pulse_tick();
    step(3);
    chk("latency_low", pif.p_valid, 0);
    step();
    chk("latency_high", pif.p_valid, 1);
    exp_pix("erase", 77, 60, 0);
    exp_pix("draw", 81, 60, 7);
    move(78, 60, 82, 60);
    move(79, 60, 83, 60);
    chk("no_eat", eat_cnt - e0, 0);

    // Reverse request discarded, then up, then left.
    set_dir(LEFT);
    move(80, 60, 84, 60);
    set_dir(UP);
    move(81, 60, 84, 59);
    set_dir(LEFT);
    move(82, 60, 83, 59);

    // Eat: no erase, growth to 8, back-pressure on draw and erase.
    food_x = 8'd82;
    food_y = 7'd59;
    e0 = eat_cnt;
    pulse_tick();
    exp_pix("eat_draw", 82, 59, 7);
    chk("eat_pulse", eat_cnt - e0, 1);
    chk("eat_score", score, 1);
    chk("eat_length", length, 5);
    food_x = 8'd0;
    food_y = 7'd0;
    pulse_tick();
    exp_pix("grow_draw", 81, 59, 7);
    pif.p_ready = 1'b0;
    pulse_tick();
    wait_pvalid("blk_draw_wait");
    hold_check("blk_draw_hold", 80, 59, 7);
    pif.p_ready = 1'b1;
    exp_pix("grow_draw", 80, 59, 7);
    pulse_tick();
    exp_pix("grow_draw", 79, 59, 7);
    chk("grown_length", length, 8);
    pif.p_ready = 1'b0;
    pulse_tick();
    wait_pvalid("blk_erase_wait");
    hold_check("blk_erase_hold", 83, 60, 0);
    pif.p_ready = 1'b1;
    exp_pix("erase", 83, 60, 0);
    exp_pix("draw", 78, 59, 7);
    chk("full_length", length, 8);
    chk("full_score", score, 1);

    // Self-collision.
    set_dir(DOWN);
    move(84, 60, 78, 60);
    set_dir(RIGHT);
    move(84, 59, 79, 60);
    set_dir(UP);
    pulse_tick();
    wait_dead("collide_dead");
    chk("dead_no_pixel", pix_cnt - rd_idx, 0);
    pulse_tick();
    step(20);
    chk("dead_tick_ignored", pix_cnt - rd_idx, 0);
    chk("dead_p_valid", pif.p_valid, 0);
    chk("dead_length", length, 8);

    // Reset recovery, including reset while a pixel is stalled.
    pif.p_ready = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    wait_pvalid("init_stall_wait");
    reset = 1'b1;
    step();
    chk("rst_mid_p_valid", pif.p_valid, 0);
    step();
    reset = 1'b0;
    pif.p_ready = 1'b1;
    rd_idx = pix_cnt;
    chk("recover_game_over", game_over, 0);
    chk("recover_score", score, 0);
    chk("recover_length", length, 4);
    for (int i = 0; i < 4; i++) exp_pix("reinit", 80 - i, 60, 7);

    // One pending tick kept from a run of ticks during CHECK; a third is dropped.
    pulse_tick();
    step();
    pulse_tick();
    step();
    pulse_tick();
    exp_pix("pend_erase", 77, 60, 0);
    exp_pix("pend_draw", 81, 60, 7);
    exp_pix("pend_erase", 78, 60, 0);
    exp_pix("pend_draw", 82, 60, 7);
    step(30);
    chk("pend_dropped", pix_cnt - rd_idx, 0);

    // Run to the right edge.
    for (int k = 83; k <= 159; k++) move(k - 4, 60, k, 60);
`ifdef WRAP_EN
    move(156, 60, 0, 60);
    chk("wrap_alive", game_over, 0);
`else
    pulse_tick();
    wait_dead("edge_dead");
    step(10);
    chk("edge_no_pixel", pix_cnt - rd_idx, 0);
    chk("edge_p_valid", pif.p_valid, 0);
`endif
    chk("edge_length", length, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
